io_register_target: RTL and testbench
=====================================

IO_REGISTER_TARGET -- requirements
Module: io_register_target

Interface
REQ-001 The block SHALL have parameter PORTBYTEWIDTH, default 4, the IO port width in bytes; values below 4 are unsupported.
REQ-002 The block SHALL have parameter REGWIDTH, default 16, the width of each internal register; the value must not exceed PORTBYTEWIDTH*8.
REQ-003 Port clk, input, width 1: the IO target clock. There is one clock; all logic is on its rising edge.
REQ-004 Port async_rst_n, input, width 1: asynchronous, active-low reset.
REQ-005 Port IOCommandEn, input, width 1: a command word is valid.
REQ-006 Port IOREQ, input, width 1: the initiator is ready to accept a response.
REQ-007 Port IOResponseRequested, input, width 1: the command needs a register writeback.
REQ-008 Port IODestRegIn, input, width 4: the destination register tag of the command.
REQ-009 Port IODataIn, input, width PORTBYTEWIDTH*8: the command word.
REQ-010 Port IOACK, output, width 1: handshake qualifier for both the command and the response direction.
REQ-011 Port IOCommandResponse, output, width 1: the target consumes the command on this cycle.
REQ-012 Port IORegResponseFlag, output, width 1: the response carries a register writeback.
REQ-013 Port IOMemResponseFlag, output, width 1: the response updates the initiator buffer only.
REQ-014 Port IODestRegOut, output, width 4: the destination register tag echoed back with the response.
REQ-015 Port IODataOut, output, width PORTBYTEWIDTH*8: the response data.

Function
REQ-016 The block SHALL hold four REGWIDTH-bit registers, R0 to R3.
REQ-017 The command word SHALL decode as follows:
- op = IODataIn[29:28]
- idx = IODataIn[25:24]
- val = IODataIn[REGWIDTH-1:0]
- IODataIn[31:27] = 5'h1F is the reserved clock opcode.
REQ-018 The FSM SHALL have three states:
- IDLE: IOACK=1, IOCommandResponse=1, both response flags 0.
- EXEC: all handshake outputs 0.
- RESP: IOACK=1, IOCommandResponse=0, exactly one response flag 1.
REQ-019 A command SHALL be accepted in IDLE when IOCommandEn=1.
- On acceptance, op, idx, val, IODestRegIn and IOResponseRequested are latched.
- The FSM then moves to EXEC.
REQ-020 A command carrying the reserved clock opcode SHALL be consumed in IDLE with no register change and no response, and the FSM SHALL stay in IDLE.
REQ-021 In EXEC (one cycle) the block SHALL execute the latched op; old = the R[idx] value before the op:
- 00 WRITE: R[idx] <= val; response data = val.
- 01 READ: R[idx] unchanged; response data = old.
- 10 SWAP: R[idx] <= val; response data = old.
- 11 ADD: R[idx] <= (old + val) mod 2^REGWIDTH; response data = old.
REQ-022 Response data SHALL be registered at the end of EXEC and driven on IODataOut zero-extended to PORTBYTEWIDTH*8 bits.
REQ-023 The response flag SHALL be selected from the latched request bit:
- IORegResponseFlag=1 if the latched IOResponseRequested=1.
- IOMemResponseFlag=1 otherwise.
- The two flags are never 1 together.
REQ-024 IODestRegOut SHALL equal the latched IODestRegIn while in RESP.
REQ-025 The response SHALL transfer in RESP on the cycle IOREQ=1, and the FSM SHALL then return to IDLE.
- If IOREQ=0, RESP holds indefinitely.
- All response outputs stay stable while RESP holds.
REQ-026 No command SHALL be accepted in EXEC or RESP; IOCommandResponse=0 there, regardless of IOCommandEn.
REQ-027 Latency SHALL be: command accepted at edge T, register updated at edge T+1, response outputs valid from T+1 to the transfer edge.
- Best-case throughput is one command per 3 cycles.
REQ-028 Outside RESP, IODataOut and IODestRegOut SHALL hold their last values.

Reset
REQ-029 While async_rst_n=0, the block SHALL immediately force:
- state = IDLE
- R0 to R3 = 0
- IODataOut = 0 and IODestRegOut = 0
- IOACK = 0, IOCommandResponse = 0, both response flags 0.
REQ-030 Reset asserted in EXEC or RESP SHALL abort the command; no response is issued after release.
REQ-031 After async_rst_n rises, IDLE outputs (IOACK=1, IOCommandResponse=1) SHALL appear from the first clk edge.

Verification
REQ-032 Write then read:
- Stimulus: WRITE idx=2 val=16'hBEEF with request=0, then READ idx=2 with request=1 and dest=4'h7.
- Required: first response Mem flag with data 32'h0000BEEF; second response Reg flag with dest 7 and data 32'h0000BEEF.
REQ-033 ADD wrap:
- Stimulus: R1=16'hFFFF, then ADD val=16'h0003.
- Required: response data 32'h0000FFFF; a following READ returns 32'h00000002.
REQ-034 SWAP:
- Stimulus: R0=16'h1234, then SWAP val=16'h5678.
- Required: response data 32'h00001234; R0=16'h5678.
REQ-035 Back-pressure:
- Stimulus: hold IOREQ=0 for 10 cycles in RESP while IOCommandEn=1.
- Required: IOCommandResponse=0 throughout; flags, dest and data stable; on IOREQ=1 the FSM returns to IDLE, and the pending command is accepted the next cycle.
REQ-036 Reserved clock opcode:
- Stimulus: IODataIn=32'hF8000000.
- Required: consumed in one cycle, no flag asserted, all registers unchanged.
REQ-037 Reset mid-operation:
- Stimulus: drop async_rst_n in RESP.
- Required: flags go 0 immediately; after release, R0 to R3 read 0 and no stale response is issued.

Source files
------------

// File: rtl/io_register_target.sv
// io_register_target: four-register IO target executing WRITE/READ/SWAP/ADD commands with a handshaked response
module io_register_target #(
  parameter int PORTBYTEWIDTH = 4,
  parameter int REGWIDTH      = 16
) (
  input  logic                       clk,
  input  logic                       async_rst_n,
  input  logic                       IOCommandEn,
  input  logic                       IOREQ,
  input  logic                       IOResponseRequested,
  input  logic [3:0]                 IODestRegIn,
  input  logic [PORTBYTEWIDTH*8-1:0] IODataIn,
  output logic                       IOACK,
  output logic                       IOCommandResponse,
  output logic                       IORegResponseFlag,
  output logic                       IOMemResponseFlag,
  output logic [3:0]                 IODestRegOut,
  output logic [PORTBYTEWIDTH*8-1:0] IODataOut
);
  localparam int DW = PORTBYTEWIDTH * 8;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t              state_q;
  logic [1:0]          op_q, idx_q;
  logic [REGWIDTH-1:0] val_q;
  logic [3:0]          dest_q, dest_out_q;
  logic                req_q;
  logic [REGWIDTH-1:0] r_q [4];
  logic                ack_q, cmd_q, regf_q, memf_q;
  logic [DW-1:0]       data_q, data_d;
  logic [REGWIDTH-1:0] old_d, r_d;
  logic                reserved;
  logic                unused_bits;
  assign reserved    = IODataIn[31:27] == 5'h1F;
  assign unused_bits = ^IODataIn;
  assign IOACK             = ack_q;
  assign IOCommandResponse = cmd_q;
  assign IORegResponseFlag = regf_q;
  assign IOMemResponseFlag = memf_q;
  assign IODestRegOut      = dest_out_q;
  assign IODataOut         = data_q;
  // Result of the latched op: new register value and zero-extended response word
  always_comb begin
    old_d  = r_q[idx_q];
    r_d    = op_q == 2'b01 ? old_d : op_q == 2'b11 ? old_d + val_q : val_q;
    data_d = '0;
    data_d[REGWIDTH-1:0] = op_q == 2'b00 ? val_q : old_d;
  end
  // Command FSM with registered handshake outputs; cmd_q gates acceptance so the first edge after reset only raises IDLE outputs
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state_q    <= IDLE;
      for (int i = 0; i < 4; i++) r_q[i] <= '0;
      op_q       <= '0;
      idx_q      <= '0;
      val_q      <= '0;
      dest_q     <= '0;
      req_q      <= 1'b0;
      ack_q      <= 1'b0;
      cmd_q      <= 1'b0;
      regf_q     <= 1'b0;
      memf_q     <= 1'b0;
      dest_out_q <= '0;
      data_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          ack_q <= 1'b1;
          cmd_q <= 1'b1;
          if (cmd_q && IOCommandEn && !reserved) begin
            op_q    <= IODataIn[29:28];
            idx_q   <= IODataIn[25:24];
            val_q   <= IODataIn[REGWIDTH-1:0];
            dest_q  <= IODestRegIn;
            req_q   <= IOResponseRequested;
            ack_q   <= 1'b0;
            cmd_q   <= 1'b0;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          r_q[idx_q] <= r_d;
          data_q     <= data_d;
          dest_out_q <= dest_q;
          regf_q     <= req_q;
          memf_q     <= !req_q;
          ack_q      <= 1'b1;
          state_q    <= RESP;
        end
        RESP: begin
          if (IOREQ) begin
            cmd_q   <= 1'b1;
            regf_q  <= 1'b0;
            memf_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_io_register_target.sv
// tb_io_register_target: directed-vector bench for io_register_target
module tb_io_register_target;
  logic        clk = 1'b0;
  logic        async_rst_n = 1'b1;
  logic        IOCommandEn = 1'b0;
  logic        IOREQ = 1'b1;
  logic        IOResponseRequested = 1'b0;
  logic [3:0]  IODestRegIn = '0;
  logic [31:0] IODataIn = '0;
  logic        IOACK, IOCommandResponse, IORegResponseFlag, IOMemResponseFlag;
  logic [3:0]  IODestRegOut;
  logic [31:0] IODataOut;
  int checks = 0;
  int errors = 0;

  io_register_target #(.PORTBYTEWIDTH(4), .REGWIDTH(16)) dut (
    .clk(clk), .async_rst_n(async_rst_n), .IOCommandEn(IOCommandEn), .IOREQ(IOREQ),
    .IOResponseRequested(IOResponseRequested), .IODestRegIn(IODestRegIn), .IODataIn(IODataIn),
    .IOACK(IOACK), .IOCommandResponse(IOCommandResponse), .IORegResponseFlag(IORegResponseFlag),
    .IOMemResponseFlag(IOMemResponseFlag), .IODestRegOut(IODestRegOut), .IODataOut(IODataOut)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Full command with IOREQ=1: accept, exec, response check, return to IDLE
  task automatic run_cmd(input string tag, input logic [31:0] word, input logic req,
                         input logic [3:0] dest, input logic [31:0] exp);
    chk({tag, "_rdy"}, {IOACK, IOCommandResponse}, 2'b11);
    IOCommandEn = 1'b1;
    IODataIn = word;
    IOResponseRequested = req;
    IODestRegIn = dest;
    tick();
    IOCommandEn = 1'b0;
    chk({tag, "_exec"}, {IOACK, IOCommandResponse, IORegResponseFlag, IOMemResponseFlag}, 4'b0000);
    tick();
    chk({tag, "_flags"}, {IOACK, IOCommandResponse, IORegResponseFlag, IOMemResponseFlag}, {2'b10, req, !req});
    chk({tag, "_dest"}, IODestRegOut, dest);
    chk({tag, "_data"}, IODataOut, exp);
    tick();
    chk({tag, "_idle"}, {IOACK, IOCommandResponse, IORegResponseFlag, IOMemResponseFlag}, 4'b1100);
  endtask

  initial begin
    #1 async_rst_n = 1'b0;
    #2;
    chk("rst_hs", {IOACK, IOCommandResponse, IORegResponseFlag, IOMemResponseFlag}, 4'b0000);
    chk("rst_data", IODataOut, 32'h0);
    chk("rst_dest", IODestRegOut, 4'h0);
    @(negedge clk);
    @(negedge clk);
    async_rst_n = 1'b1;
    tick();
    chk("post_rst_idle", {IOACK, IOCommandResponse, IORegResponseFlag, IOMemResponseFlag}, 4'b1100);

    run_cmd("wr_r2", 32'h0200BEEF, 1'b0, 4'h0, 32'h0000BEEF);
    run_cmd("rd_r2", 32'h12000000, 1'b1, 4'h7, 32'h0000BEEF);

    run_cmd("wr_r1", 32'h0100FFFF, 1'b0, 4'h1, 32'h0000FFFF);
    run_cmd("add_r1", 32'h31000003, 1'b1, 4'h2, 32'h0000FFFF);
    run_cmd("rd_r1", 32'h11000000, 1'b0, 4'h3, 32'h00000002);

    run_cmd("wr_r0", 32'h00001234, 1'b0, 4'h4, 32'h00001234);
    run_cmd("swap_r0", 32'h20005678, 1'b1, 4'h5, 32'h00001234);
    run_cmd("rd_r0", 32'h10000000, 1'b0, 4'h6, 32'h00005678);

    IOCommandEn = 1'b1;
    IODataIn = 32'hF8000000;
    IOResponseRequested = 1'b1;
    tick();
    IOCommandEn = 1'b0;
    chk("rsv_idle", {IOACK, IOCommandResponse, IORegResponseFlag, IOMemResponseFlag}, 4'b1100);
    chk("rsv_data_hold", IODataOut, 32'h00005678);
    chk("rsv_dest_hold", IODestRegOut, 4'h6);
    tick();
    chk("rsv_still_idle", {IORegResponseFlag, IOMemResponseFlag}, 2'b00);
    run_cmd("rsv_rd_r0", 32'h10000000, 1'b0, 4'h0, 32'h00005678);
    run_cmd("rsv_rd_r1", 32'h11000000, 1'b0, 4'h1, 32'h00000002);
    run_cmd("rsv_rd_r2", 32'h12000000, 1'b0, 4'h2, 32'h0000BEEF);
    run_cmd("rsv_rd_r3", 32'h13000000, 1'b0, 4'h3, 32'h00000000);

    IOREQ = 1'b0;
    IOCommandEn = 1'b1;
    IODataIn = 32'h0300A5A5;
    IOResponseRequested = 1'b1;
    IODestRegIn = 4'h9;
    tick();
    IODataIn = 32'h13000000;
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("bp_cmdresp", {IOACK, IOCommandResponse}, 2'b10);
      chk("bp_flags", {IORegResponseFlag, IOMemResponseFlag}, 2'b10);
      chk("bp_dest", IODestRegOut, 4'h9);
      chk("bp_data", IODataOut, 32'h0000A5A5);
      tick();
    end
    IOREQ = 1'b1;
    tick();
    chk("bp_idle", {IOACK, IOCommandResponse, IORegResponseFlag, IOMemResponseFlag}, 4'b1100);
    tick();
    IOCommandEn = 1'b0;
    chk("bp_pending_exec", {IOACK, IOCommandResponse}, 2'b00);
    tick();
    chk("bp_pending_flags", {IORegResponseFlag, IOMemResponseFlag}, 2'b10);
    chk("bp_pending_data", IODataOut, 32'h0000A5A5);
    tick();
    chk("bp_pending_done", {IOACK, IOCommandResponse}, 2'b11);

    IOREQ = 1'b0;
    IOCommandEn = 1'b1;
    IODataIn = 32'h01007777;
    IOResponseRequested = 1'b0;
    IODestRegIn = 4'hC;
    tick();
    IOCommandEn = 1'b0;
    tick();
    chk("mid_resp", {IORegResponseFlag, IOMemResponseFlag}, 2'b01);
    #2 async_rst_n = 1'b0;
    #1;
    chk("mid_rst_hs", {IOACK, IOCommandResponse, IORegResponseFlag, IOMemResponseFlag}, 4'b0000);
    chk("mid_rst_data", IODataOut, 32'h0);
    chk("mid_rst_dest", IODestRegOut, 4'h0);
    @(negedge clk);
    async_rst_n = 1'b1;
    IOREQ = 1'b1;
    tick();
    chk("mid_post_idle", {IOACK, IOCommandResponse, IORegResponseFlag, IOMemResponseFlag}, 4'b1100);
    tick();
    chk("mid_no_stale", {IORegResponseFlag, IOMemResponseFlag}, 2'b00);
    run_cmd("mid_rd_r0", 32'h10000000, 1'b0, 4'h0, 32'h0);
    run_cmd("mid_rd_r1", 32'h11000000, 1'b0, 4'h1, 32'h0);
    run_cmd("mid_rd_r2", 32'h12000000, 1'b0, 4'h2, 32'h0);
    run_cmd("mid_rd_r3", 32'h13000000, 1'b0, 4'h3, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
